// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants, entry types and writeback priority for the reorder buffer
package rob_pkg;

    localparam int TAG_W      = 5;
    localparam int DEPTH      = 32;
    localparam int ARCH_REG_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  live;
        logic                  ready;
        logic [ARCH_REG_W-1:0] rd;
        logic [DATA_W-1:0]     val;
    } rob_entry_t;

    typedef struct packed {
        logic              en;
        logic [TAG_W-1:0]  vregid;
        logic [DATA_W-1:0] val;
    } wb_bus_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] val;
    } wb_hit_t;

    // Bus 1 wins over bus 2 which wins over bus 3 when several carry the same tag.
    function automatic wb_hit_t wb_select(input wb_bus_t wb1, input wb_bus_t wb2,
                                          input wb_bus_t wb3, input logic [TAG_W-1:0] tag);
        wb_hit_t r;
        r.hit = 1'b1;
        if (wb1.en && wb1.vregid == tag)      r.val = wb1.val;
        else if (wb2.en && wb2.vregid == tag) r.val = wb2.val;
        else if (wb3.en && wb3.vregid == tag) r.val = wb3.val;
        else begin
            r.hit = 1'b0;
            r.val = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// rtl/rob_query_port.sv - operand readiness/value lookup with same-cycle writeback bypass
module rob_query_port
    import rob_pkg::*;
(
    input  logic [DEPTH-1:0]  live,
    input  logic [DEPTH-1:0]  ready_st,
    input  logic [DATA_W-1:0] vals [DEPTH],
    input  wb_bus_t           wb1,
    input  wb_bus_t           wb2,
    input  wb_bus_t           wb3,
    input  logic [TAG_W-1:0]  tag,
    output logic              ready,
    output logic [DATA_W-1:0] val
);

    wb_hit_t byp;

    // A live tag is ready if stored ready or written back this cycle; the bus value wins.
    always_comb begin
        byp   = wb_select(wb1, wb2, wb3, tag);
        ready = live[tag] && (ready_st[tag] || byp.hit);
        val   = '0;
        if (ready) val = byp.hit ? byp.val : vals[tag];
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer allocating vreg tags
module reorder_buffer
    import rob_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  logic [ARCH_REG_W-1:0] alloc_rd,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  full,
    output logic                  empty,
    input  logic                  wb1_en,
    input  logic [TAG_W-1:0]      wb1_vregid,
    input  logic [DATA_W-1:0]     wb1_val,
    input  logic                  wb2_en,
    input  logic [TAG_W-1:0]      wb2_vregid,
    input  logic [DATA_W-1:0]     wb2_val,
    input  logic                  wb3_en,
    input  logic [TAG_W-1:0]      wb3_vregid,
    input  logic [DATA_W-1:0]     wb3_val,
    input  logic [TAG_W-1:0]      q1_tag,
    output logic                  q1_ready,
    output logic [DATA_W-1:0]     q1_val,
    input  logic [TAG_W-1:0]      q2_tag,
    output logic                  q2_ready,
    output logic [DATA_W-1:0]     q2_val,
    output logic                  commit_en,
    output logic [ARCH_REG_W-1:0] commit_rd,
    output logic [TAG_W-1:0]      commit_tag,
    output logic [DATA_W-1:0]     commit_val
);

    rob_entry_t        entries [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    wb_bus_t           wb1, wb2, wb3;
    wb_hit_t           wb_hits [DEPTH];
    logic [DEPTH-1:0]  live_vec;
    logic [DEPTH-1:0]  ready_vec;
    logic [DATA_W-1:0] val_vec [DEPTH];
    logic              do_alloc;
    logic              do_commit;

    assign wb1 = '{en: wb1_en, vregid: wb1_vregid, val: wb1_val};
    assign wb2 = '{en: wb2_en, vregid: wb2_vregid, val: wb2_val};
    assign wb3 = '{en: wb3_en, vregid: wb3_vregid, val: wb3_val};

    // Two slots of slack so the registered dispatch stage can still land its allocations.
    assign full      = count >= (TAG_W+1)'(DEPTH - 2);
    assign empty     = count == '0;
    assign alloc_tag = tail;
    assign do_alloc  = alloc_en && !flush;
    assign do_commit = entries[head].live && entries[head].ready && !flush;

    // Per-entry writeback match and flattened views for the query ports.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wb_hits[i]   = wb_select(wb1, wb2, wb3, TAG_W'(i));
            live_vec[i]  = entries[i].live;
            ready_vec[i] = entries[i].ready;
            val_vec[i]   = entries[i].val;
        end
    end

    // Buffer state: flush/reset clear everything, otherwise capture, retire and allocate.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].live  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            commit_en  <= 1'b0;
            commit_rd  <= '0;
            commit_tag <= '0;
            commit_val <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].live && !entries[i].ready && wb_hits[i].hit) begin
                    entries[i].ready <= 1'b1;
                    entries[i].val   <= wb_hits[i].val;
                end
            end
            commit_en <= do_commit;
            if (do_commit) begin
                commit_rd          <= entries[head].rd;
                commit_tag         <= head;
                commit_val         <= entries[head].val;
                entries[head].live <= 1'b0;
                head               <= head + 1'b1;
            end
            if (do_alloc) begin
                entries[tail] <= '{live: 1'b1, ready: 1'b0, rd: alloc_rd, val: '0};
                tail          <= tail + 1'b1;
            end
            count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end

    // Allocating into a completely full buffer means dispatch ignored full.
    always_ff @(posedge clk) begin
        if (!rst && do_alloc && count == (TAG_W+1)'(DEPTH))
            $fatal(1, "reorder_buffer: allocation while all entries are live");
    end

    rob_query_port u_q1 (
        .live     (live_vec),
        .ready_st (ready_vec),
        .vals     (val_vec),
        .wb1      (wb1),
        .wb2      (wb2),
        .wb3      (wb3),
        .tag      (q1_tag),
        .ready    (q1_ready),
        .val      (q1_val)
    );

    rob_query_port u_q2 (
        .live     (live_vec),
        .ready_st (ready_vec),
        .vals     (val_vec),
        .wb1      (wb1),
        .wb2      (wb2),
        .wb3      (wb3),
        .tag      (q2_tag),
        .ready    (q2_ready),
        .val      (q2_val)
    );

endmodule
